apb_master: RTL and testbench

- Single-outstanding APB3 requester that turns a simple valid/ready command interface into APB transfers toward peripherals such as the 8-bit timer.
- Returns one response per command with read data and error status.
- Includes a wait-state watchdog so a hung slave cannot stall the requester.
- Used by the bench/CPU-side subsystem as the initiator end of the APB bus.

---
 rtl/apb_master.sv | 125 ++++++++++++
 tb/tb_apb_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: turns valid/ready commands into APB
// transfers, returns one response per command, and aborts hung slaves.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter keeps a legal width even when the watchdog is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          done;
  logic          abort;
  logic          accept;

  // Command handshake: a command is taken on any edge where
  // cmd_valid && cmd_ready; cmd_ready is high in IDLE and on the completing
  // ACCESS cycle so a held cmd_valid chains transfers with no idle gap.
  assign done      = (state == ACCESS) && PREADY;
  assign abort     = (TIMEOUT > 0) && (state == ACCESS) && !PREADY && (wait_cnt == LIMIT);
  assign cmd_ready = (state == IDLE) || done;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            PENABLE     <= 1'b0;
            if (accept) begin
              // Back-to-back: PSEL stays high, straight into the next SETUP.
              PWRITE <= cmd_write;
              PADDR  <= cmd_addr;
              PWDATA <= cmd_wdata;
              state  <= SETUP;
            end else begin
              PSEL  <= 1'b0;
              state <= IDLE;
            end
          end else if (abort) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a driven slave model, a response scoreboard
// holding {timeout, err, rdata} and signal-timing checks around each transfer.
module tb_apb_master;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RSP_W  = DATA_W + 2;

  logic              PCLK;
  logic              PRESETn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [1:0]        fsm_state;

  logic [RSP_W-1:0] exp_q[$];
  int n_vec;
  int n_mis;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .fsm_state(fsm_state)
  );

  // Clock
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command and holds it until accepted; returns 1 time unit
  // after the accepting edge with cmd_valid dropped.
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int guard;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    guard = 0;
    @(negedge PCLK);
    while (!cmd_ready && guard < 50) begin
      @(negedge PCLK);
      guard++;
    end
    if (guard >= 50) check("accept_wait", 32'(cmd_ready), 32'd1);
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge PCLK) begin
    if (PRESETn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {22'd0, rsp_timeout, rsp_err, rsp_rdata}, 32'hFFFF_FFFF);
      end else begin
        logic [RSP_W-1:0] e;
        e = exp_q.pop_front();
        check("rsp", 32'({rsp_timeout, rsp_err, rsp_rdata}), 32'(e));
      end
    end
  end

  initial begin
    n_vec = 0;
    n_mis = 0;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_outputs", {PSEL, PENABLE, PWRITE, busy, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
    check("rst_bus", {PADDR, PWDATA, rsp_rdata}, 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    PRESETn = 1'b1;
    step();

    // 1: write 0x91 -> 0x00, zero waits
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    issue(1'b1, 8'h00, 8'h91);
    check("w_setup", {PSEL, PENABLE, busy, PWRITE}, 32'b1011);
    check("w_bus", {PADDR, PWDATA}, 32'h0091);
    check("w_setup_ready", 32'(cmd_ready), 32'd0);
    step();
    check("w_access", {PSEL, PENABLE}, 32'b11);
    step();
    check("w_done", {rsp_valid, PSEL, PENABLE, busy}, 32'b1000);
    step();
    check("w_pulse_one", 32'(rsp_valid), 32'd0);

    // 2: read 0x02 with 3 wait states
    PREADY = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    issue(1'b0, 8'h02, 8'h00);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("r_wait_ctl", {PSEL, PENABLE, PWRITE, rsp_valid, cmd_ready}, 32'b11000);
      check("r_wait_addr", 32'(PADDR), 32'h02);
    end
    PREADY = 1'b1;
    PRDATA = 8'hA5;
    step();
    check("r_done", {rsp_valid, PSEL, busy}, 32'b100);
    PRDATA = 8'h00;
    step();

    // 3: write 0x7F with slave error
    PSLVERR = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    issue(1'b1, 8'h7F, 8'h33);
    step();
    step();
    check("err_idle", {rsp_valid, busy, fsm_state}, 32'b1000);
    PSLVERR = 1'b0;
    step();

    // 4: back-to-back, cmd_valid held across both commands
    PRDATA = 8'h3C;
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    exp_q.push_back({1'b0, 1'b0, 8'h3C});
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h10;
    cmd_wdata = 8'h01;
    step();
    check("b2b_first_setup", {PSEL, PENABLE, PADDR}, {24'd0, 2'b10, 8'h10});
    cmd_write = 1'b0;
    cmd_addr  = 8'h01;
    step();
    check("b2b_first_access", {PSEL, PENABLE}, 32'b11);
    step();
    check("b2b_second_setup", {rsp_valid, PSEL, PENABLE, busy, PWRITE, PADDR}, {24'd0, 5'b11010, 8'h01} >> 0);
    cmd_valid = 1'b0;
    step();
    check("b2b_second_access", {PSEL, PENABLE}, 32'b11);
    step();
    check("b2b_done", {rsp_valid, PSEL, busy}, 32'b100);
    PRDATA = 8'h00;
    step();

    // 5: PREADY rises on the 16th sample: normal completion, not a timeout
    PREADY = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'h6E});
    issue(1'b0, 8'h20, 8'h00);
    step();
    for (int i = 0; i < 15; i++) step();
    check("edge_still_access", {PSEL, PENABLE, rsp_valid}, 32'b110);
    PREADY = 1'b1;
    PRDATA = 8'h6E;
    step();
    check("edge_done", {rsp_valid, rsp_timeout, PSEL}, 32'b100);
    PRDATA = 8'h00;
    step();

    // 6: PREADY stuck low: abort after 16 ACCESS cycles
    PREADY = 1'b0;
    PRDATA = 8'hEE;
    exp_q.push_back({1'b1, 1'b1, 8'h00});
    issue(1'b0, 8'h05, 8'h00);
    step();
    for (int i = 0; i < 15; i++) step();
    check("to_before", {PSEL, PENABLE, rsp_valid, cmd_ready}, 32'b1100);
    step();
    check("to_abort", {rsp_valid, PSEL, PENABLE, busy}, 32'b1000);
    PREADY = 1'b1;
    PRDATA = 8'h5A;
    step();
    exp_q.push_back({1'b0, 1'b0, 8'h5A});
    issue(1'b0, 8'h06, 8'h00);
    step();
    step();
    check("to_next_done", {rsp_valid, busy}, 32'b10);
    PRDATA = 8'h00;
    step();

    // 7: asynchronous reset during ACCESS drops the command
    PREADY = 1'b0;
    issue(1'b1, 8'h44, 8'h55);
    step();
    step();
    #2;
    PRESETn = 1'b0;
    #1;
    check("arst_mid", {PSEL, PENABLE, busy, rsp_valid}, 32'd0);
    step();
    PREADY = 1'b1;
    PRESETn = 1'b1;
    step();
    check("arst_no_rsp", {rsp_valid, busy}, 32'd0);
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    issue(1'b1, 8'h12, 8'h34);
    step();
    step();
    check("arst_after_done", {rsp_valid, busy}, 32'b10);

    repeat (3) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #100000;
    n_mis++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $fatal(1, "time limit");
  end

endmodule
